// File: rtl/rf_writer.sv
// ============================================================================
// Module   : rf_writer
// Brief    : WB-stage register-file writer with queued scrub write-back and
//            starvation-forced scrub cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_writer #(
    parameter int REP_DEPTH  = 2,
    parameter int STARVE_LIM = 8,
    parameter int CNT_W      = 16
) (
    input  logic             s_clk_i,
    input  logic             s_reset_i,
    input  logic             s_stall_i,
    input  logic             s_flush_i,
    input  logic [4:0]       s_exma_rd_i,
    input  logic [31:0]      s_exma_val_i,
    input  logic             s_exma_wen_i,
    output logic [4:0]       s_mawb_rd_o,
    output logic [31:0]      s_mawb_val_o,
    output logic             s_mawb_wen_o,
    output logic             s_rf_we_o,
    output logic [4:0]       s_rf_wadd_o,
    output logic [31:0]      s_rf_wval_o,
    input  logic             s_rep_req_i,
    input  logic [4:0]       s_rep_add_i,
    input  logic [31:0]      s_rep_val_i,
    output logic             s_rep_ovf_o,
    output logic             s_rep_stall_o,
    output logic [CNT_W-1:0] s_rep_cnt_o
);

    localparam int c_pw = (REP_DEPTH > 1) ? $clog2(REP_DEPTH) : 1;
    localparam int c_cw = c_pw + 1;
    localparam int c_sw = $clog2(STARVE_LIM + 1);
    localparam logic [c_cw-1:0] c_depth      = c_cw'(REP_DEPTH);
    localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_LIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_sw-1:0]   starve_q, starve_d;
    logic              rep_stall_q, rep_stall_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        mawb_rd_q, mawb_rd_d;
    logic [31:0]       mawb_val_q, mawb_val_d;
    logic              mawb_wen_q, mawb_wen_d;
    logic [4:0]        add_q [REP_DEPTH];
    logic [4:0]        add_d [REP_DEPTH];
    logic [31:0]       val_q [REP_DEPTH];
    logic [31:0]       val_d [REP_DEPTH];
    logic              vld_q [REP_DEPTH];
    logic              vld_d [REP_DEPTH];
    logic [c_pw-1:0]   head_q, head_d, tail_q, tail_d;
    logic [c_cw-1:0]   count_q, count_d;

    logic        head_vld, mawb_write, pop, commit, dup, req_ok, push;
    logic        rf_we;
    logic [4:0]  rf_wadd;
    logic [31:0] rf_wval;

    // Write-port arbitration: forced scrub, then MAWB, then idle-cycle scrub
    always_comb begin
        head_vld   = vld_q[head_q];
        mawb_write = mawb_wen_q & ~rep_stall_q;
        pop        = 1'b0;
        commit     = 1'b0;
        rf_we      = 1'b0;
        rf_wadd    = '0;
        rf_wval    = '0;
        if (rep_stall_q) begin
            pop    = 1'b1;
            commit = head_vld;
            rf_we  = head_vld;
            if (head_vld) begin
                rf_wadd = add_q[head_q];
                rf_wval = val_q[head_q];
            end
        end else if (mawb_wen_q) begin
            rf_we   = 1'b1;
            rf_wadd = mawb_rd_q;
            rf_wval = mawb_val_q;
            pop     = (count_q != '0) & ~head_vld;
        end else if (count_q != '0) begin
            pop    = 1'b1;
            commit = head_vld;
            rf_we  = head_vld;
            if (head_vld) begin
                rf_wadd = add_q[head_q];
                rf_wval = val_q[head_q];
            end
        end
    end

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < REP_DEPTH; i++) begin
            if (vld_q[i] && (add_q[i] == s_rep_add_i)) begin
                dup = 1'b1;
            end
        end
        req_ok = s_rep_req_i & (s_rep_add_i != 5'd0) & ~dup
                 & ~(mawb_write & (s_rep_add_i == mawb_rd_q));
        push   = req_ok & ((count_q != c_depth) | pop);
        ovf_d  = req_ok & (count_q == c_depth) & ~pop;
    end

    // Queue update; a MAWB write supersedes any pending scrub of the same register
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < REP_DEPTH; i++) begin
            add_d[i] = add_q[i];
            val_d[i] = val_q[i];
            vld_d[i] = vld_q[i] & ~(mawb_write & (add_q[i] == mawb_rd_q));
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (push) begin
            add_d[tail_q] = s_rep_add_i;
            val_d[tail_q] = s_rep_val_i;
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + 1'b1;
        end
        count_d = count_q + c_cw'(push) - c_cw'(pop);
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rep_stall_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                starve_d = '0;
                if (count_d != '0) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_d == '0) begin
                    state_d  = ST_IDLE;
                    starve_d = '0;
                end else if (pop) begin
                    starve_d = '0;
                end else if ((starve_q >= c_starve_max) && mawb_write && vld_d[head_q]) begin
                    state_d     = ST_FORCE;
                    rep_stall_d = 1'b1;
                    starve_d    = '0;
                end else begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ST_FORCE: begin
                starve_d = '0;
                state_d  = (count_d != '0) ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d      = (commit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        mawb_rd_d  = mawb_rd_q;
        mawb_val_d = mawb_val_q;
        mawb_wen_d = mawb_wen_q;
        if (!s_stall_i) begin
            mawb_rd_d  = s_exma_rd_i;
            mawb_val_d = s_exma_val_i;
            mawb_wen_d = s_exma_wen_i & ~s_flush_i & (s_exma_rd_i != 5'd0);
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            rep_stall_q <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            mawb_rd_q   <= '0;
            mawb_val_q  <= '0;
            mawb_wen_q  <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < REP_DEPTH; i++) begin
                add_q[i] <= '0;
                val_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rep_stall_q <= rep_stall_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            mawb_rd_q   <= mawb_rd_d;
            mawb_val_q  <= mawb_val_d;
            mawb_wen_q  <= mawb_wen_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            for (int i = 0; i < REP_DEPTH; i++) begin
                add_q[i] <= add_d[i];
                val_q[i] <= val_d[i];
                vld_q[i] <= vld_d[i];
            end
        end
    end

    assign s_mawb_rd_o   = mawb_rd_q;
    assign s_mawb_val_o  = mawb_val_q;
    assign s_mawb_wen_o  = mawb_wen_q;
    assign s_rf_we_o     = rf_we;
    assign s_rf_wadd_o   = rf_wadd;
    assign s_rf_wval_o   = rf_wval;
    assign s_rep_ovf_o   = ovf_q;
    assign s_rep_stall_o = rep_stall_q;
    assign s_rep_cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_writer.sv
// ============================================================================
// Module   : tb_rf_writer
// Brief    : Self-checking bench for rf_writer: directed scenarios followed by
//            randomized WB traffic and isolated scrubs against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_writer;

    localparam int STARVE_LIM = 8;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall_drv = 1'b0;
    logic             stall;
    logic             flush = 1'b0;
    logic [4:0]       exma_rd = '0;
    logic [31:0]      exma_val = '0;
    logic             exma_wen = 1'b0;
    logic [4:0]       mawb_rd;
    logic [31:0]      mawb_val;
    logic             mawb_wen;
    logic             rf_we;
    logic [4:0]       rf_wadd;
    logic [31:0]      rf_wval;
    logic             rep_req = 1'b0;
    logic [4:0]       rep_add = '0;
    logic [31:0]      rep_val = '0;
    logic             rep_ovf;
    logic             rep_stall;
    logic [CNT_W-1:0] rep_cnt;

    int passed = 0;
    int total  = 0;

    // The pipeline controller stalls on every forced-scrub cycle
    assign stall = stall_drv | rep_stall;

    always #5 clk = ~clk;

    rf_writer #(.REP_DEPTH(2), .STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)) dut (
        .s_clk_i      (clk),
        .s_reset_i    (rst),
        .s_stall_i    (stall),
        .s_flush_i    (flush),
        .s_exma_rd_i  (exma_rd),
        .s_exma_val_i (exma_val),
        .s_exma_wen_i (exma_wen),
        .s_mawb_rd_o  (mawb_rd),
        .s_mawb_val_o (mawb_val),
        .s_mawb_wen_o (mawb_wen),
        .s_rf_we_o    (rf_we),
        .s_rf_wadd_o  (rf_wadd),
        .s_rf_wval_o  (rf_wval),
        .s_rep_req_i  (rep_req),
        .s_rep_add_i  (rep_add),
        .s_rep_val_i  (rep_val),
        .s_rep_ovf_o  (rep_ovf),
        .s_rep_stall_o(rep_stall),
        .s_rep_cnt_o  (rep_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(rf_we),     32'd0);
        check({tag, "_wadd"},  32'(rf_wadd),   32'd0);
        check({tag, "_wval"},  rf_wval,        32'd0);
        check({tag, "_mrd"},   32'(mawb_rd),   32'd0);
        check({tag, "_mval"},  mawb_val,       32'd0);
        check({tag, "_mwen"},  32'(mawb_wen),  32'd0);
        check({tag, "_ovf"},   32'(rep_ovf),   32'd0);
        check({tag, "_stall"}, 32'(rep_stall), 32'd0);
        check({tag, "_cnt"},   32'(rep_cnt),   32'd0);
    endtask

    initial begin
        int          exp_cnt;
        logic [4:0]  m_rd;
        logic [31:0] m_val;
        logic        m_wen;
        logic [4:0]  r_rd;
        logic        r_wen;
        logic        r_flush;
        logic [31:0] r_val;
        logic        r_stall;
        logic [4:0]  s_add;
        logic [31:0] s_val;
        logic        force_cyc;

        exp_cnt = 0;

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // MA result lands in the RF one clock later
        exma_wen = 1'b1; exma_rd = 5'd5; exma_val = 32'hDEADBEEF;
        step();
        check("t1_we",   32'(rf_we),    32'd1);
        check("t1_wadd", 32'(rf_wadd),  32'd5);
        check("t1_wval", rf_wval,       32'hDEADBEEF);
        check("t1_mrd",  32'(mawb_rd),  32'd5);
        check("t1_mval", mawb_val,      32'hDEADBEEF);
        check("t1_mwen", 32'(mawb_wen), 32'd1);

        // rd == 0 and flush both suppress the write
        exma_rd = 5'd0;
        step();
        check("t2_rd0_mwen", 32'(mawb_wen), 32'd0);
        check("t2_rd0_we",   32'(rf_we),    32'd0);
        exma_rd = 5'd6; flush = 1'b1;
        step();
        check("t2_fl_mwen", 32'(mawb_wen), 32'd0);
        check("t2_fl_we",   32'(rf_we),    32'd0);
        flush = 1'b0; exma_wen = 1'b0;

        // Idle-port scrub
        rep_req = 1'b1; rep_add = 5'd7; rep_val = 32'h12;
        step();
        rep_req = 1'b0;
        check("t3_we",   32'(rf_we),   32'd1);
        check("t3_wadd", 32'(rf_wadd), 32'd7);
        check("t3_wval", rf_wval,      32'h12);
        step();
        exp_cnt = 1;
        check("t3_cnt", 32'(rep_cnt), 32'(exp_cnt));
        check("t3_we0", 32'(rf_we),   32'd0);

        // Queue {3,9}; WB write to r3 supersedes the pending scrub of r3
        exma_wen = 1'b1; exma_rd = 5'd20; exma_val = 32'h20;
        step();
        rep_req = 1'b1; rep_add = 5'd3; rep_val = 32'h333; exma_rd = 5'd21; exma_val = 32'h21;
        step();
        rep_add = 5'd9; rep_val = 32'h999; exma_rd = 5'd3; exma_val = 32'h3003;
        step();
        rep_req = 1'b0; exma_wen = 1'b0;
        check("t4_wb3_wadd", 32'(rf_wadd), 32'd3);
        check("t4_wb3_wval", rf_wval,      32'h3003);
        step();
        check("t4_skip_we", 32'(rf_we), 32'd0);
        step();
        check("t4_s9_we",   32'(rf_we),   32'd1);
        check("t4_s9_wadd", 32'(rf_wadd), 32'd9);
        check("t4_s9_wval", rf_wval,      32'h999);
        step();
        exp_cnt++;
        check("t4_cnt", 32'(rep_cnt), 32'(exp_cnt));
        check("t4_we0", 32'(rf_we),   32'd0);

        // Starved scrub of r4 under continuous WB traffic
        exma_wen = 1'b1; exma_rd = 5'd10; exma_val = 32'hC000_000A;
        step();
        rep_req = 1'b1; rep_add = 5'd4; rep_val = 32'hAB; exma_rd = 5'd11; exma_val = 32'hC000_000B;
        step();
        rep_req = 1'b0;
        m_rd = 5'd11; m_val = 32'hC000_000B;
        for (int i = 1; i <= 20; i++) begin
            force_cyc = (i == STARVE_LIM + 1);
            check("t5_stall", 32'(rep_stall), 32'(force_cyc));
            check("t5_we",    32'(rf_we),     32'd1);
            check("t5_wadd",  32'(rf_wadd),   force_cyc ? 32'd4 : 32'(m_rd));
            check("t5_wval",  rf_wval,        force_cyc ? 32'hAB : m_val);
            exma_rd  = 5'(10 + (i % 8));
            exma_val = 32'hC000_0000 | 32'(exma_rd);
            step();
            if (!force_cyc) begin
                m_rd  = exma_rd;
                m_val = exma_val;
            end
        end
        exma_wen = 1'b0;
        step();
        exp_cnt++;
        check("t5_cnt", 32'(rep_cnt), 32'(exp_cnt));

        // Overflow on a full queue, then push-with-pop on a full queue
        exma_wen = 1'b1; exma_rd = 5'd20;
        step();
        rep_req = 1'b1; rep_add = 5'd1; rep_val = 32'h101; exma_rd = 5'd21;
        step();
        rep_add = 5'd2; rep_val = 32'h102;
        step();
        rep_add = 5'd3; rep_val = 32'h103;
        step();
        check("t6_ovf", 32'(rep_ovf), 32'd1);
        rep_req = 1'b0; exma_wen = 1'b0;
        step();
        check("t6_ovf_clr", 32'(rep_ovf), 32'd0);
        check("t6_s1_wadd", 32'(rf_wadd), 32'd1);
        rep_req = 1'b1; rep_add = 5'd5; rep_val = 32'h105;
        step();
        rep_req = 1'b0;
        exp_cnt++;
        check("t6_pp_ovf",  32'(rep_ovf), 32'd0);
        check("t6_s2_wadd", 32'(rf_wadd), 32'd2);
        step();
        exp_cnt++;
        check("t6_s5_we",   32'(rf_we),   32'd1);
        check("t6_s5_wadd", 32'(rf_wadd), 32'd5);
        check("t6_s5_wval", rf_wval,      32'h105);
        step();
        exp_cnt++;
        check("t6_cnt", 32'(rep_cnt), 32'(exp_cnt));

        // Reset while a scrub is waiting
        exma_wen = 1'b1; exma_rd = 5'd20; exma_val = 32'h5A;
        step();
        rep_req = 1'b1; rep_add = 5'd6; rep_val = 32'h106;
        step();
        rep_req = 1'b0;
        step();
        rst = 1'b1;
        #2;
        exp_cnt = 0;
        check_all_zero("midrst");
        exma_wen = 1'b0; exma_rd = 5'd0; exma_val = 32'd0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_we", 32'(rf_we), 32'd0);
        end

        // Random WB traffic with stalls and flushes; scrub queue stays empty
        m_rd = 5'd0; m_val = 32'd0; m_wen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r_rd    = 5'($urandom_range(0, 31));
            r_val   = $urandom;
            r_wen   = 1'($urandom_range(0, 1));
            r_flush = ($urandom_range(0, 3) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            exma_rd = r_rd; exma_val = r_val; exma_wen = r_wen; flush = r_flush; stall_drv = r_stall;
            step();
            if (!r_stall) begin
                m_rd  = r_rd;
                m_val = r_val;
                m_wen = r_wen && !r_flush && (r_rd != 5'd0);
            end
            check("rnd_mrd",  32'(mawb_rd),  32'(m_rd));
            check("rnd_mwen", 32'(mawb_wen), 32'(m_wen));
            check("rnd_we",   32'(rf_we),    32'(m_wen));
            check("rnd_wadd", 32'(rf_wadd),  m_wen ? 32'(m_rd) : 32'd0);
            check("rnd_wval", rf_wval,       m_wen ? m_val : 32'd0);
        end
        exma_wen = 1'b0; flush = 1'b0; stall_drv = 1'b0;
        step();
        check("rnd_cnt0", 32'(rep_cnt), 32'd0);

        // Random isolated scrubs on an idle write port
        for (int i = 0; i < 40; i++) begin
            s_add = 5'($urandom_range(0, 31));
            s_val = $urandom;
            rep_req = 1'b1; rep_add = s_add; rep_val = s_val;
            step();
            rep_req = 1'b0;
            check("rs_we",   32'(rf_we),   32'(s_add != 5'd0));
            check("rs_wadd", 32'(rf_wadd), 32'(s_add));
            check("rs_wval", rf_wval,      (s_add != 5'd0) ? s_val : 32'd0);
            step();
            if (s_add != 5'd0) exp_cnt++;
            check("rs_cnt", 32'(rep_cnt), 32'(exp_cnt));
            check("rs_we0", 32'(rf_we),   32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
